monster_move_scheduler: RTL



---
 rtl/monster_pkg.sv | 42 ++++
 rtl/monster_step.sv | 74 +++++++
 rtl/monster_move_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/monster_pkg.sv
// Shared monster definitions: table size, sprite geometry, state-word layout and direction codes.
// Used by the move scheduler and the per-pixel renderer.
package monster_pkg;

  localparam int unsigned MONSTERS = 12;
  localparam int unsigned MONS_W   = 20;
  localparam int unsigned MONS_H   = 21;
  localparam int unsigned X_MAX    = 256 - MONS_W;
  localparam int unsigned Y_MAX    = 256 - MONS_H;

  localparam int unsigned STATE_W   = 19;
  localparam int unsigned ALIVE_BIT = 0;
  localparam int unsigned DIR_LSB   = 1;
  localparam int unsigned X_LSB     = 3;
  localparam int unsigned Y_LSB     = 11;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    dir_t       dir;
    logic       alive;
  } mon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_ACK
  } sched_state_t;

  // Flipping the low bit swaps up<->down and left<->right.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/monster_step.sv
// Combinational one-frame step of a single monster state word.
// `MONSTER_BOUNCE_EN selects edge clamp with reversal; otherwise coordinates wrap modulo 256.
module monster_step
  import monster_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  mon_state_t cur,
  output mon_state_t nxt
);

`ifdef MONSTER_BOUNCE_EN
  logic [8:0] y_dec, y_inc, x_dec, x_inc;

  always_comb begin
    y_dec = {1'b0, cur.y} - 9'(STEP);
    y_inc = {1'b0, cur.y} + 9'(STEP);
    x_dec = {1'b0, cur.x} - 9'(STEP);
    x_inc = {1'b0, cur.x} + 9'(STEP);
    nxt   = cur;
    if (cur.alive) begin
      unique case (cur.dir)
        DIR_UP:
          if (y_dec[8]) begin
            nxt.y   = '0;
            nxt.dir = reverse_dir(cur.dir);
          end else begin
            nxt.y = y_dec[7:0];
          end
        DIR_DOWN:
          if (y_inc > 9'(Y_MAX)) begin
            nxt.y   = 8'(Y_MAX);
            nxt.dir = reverse_dir(cur.dir);
          end else begin
            nxt.y = y_inc[7:0];
          end
        DIR_LEFT:
          if (x_dec[8]) begin
            nxt.x   = '0;
            nxt.dir = reverse_dir(cur.dir);
          end else begin
            nxt.x = x_dec[7:0];
          end
        DIR_RIGHT:
          if (x_inc > 9'(X_MAX)) begin
            nxt.x   = 8'(X_MAX);
            nxt.dir = reverse_dir(cur.dir);
          end else begin
            nxt.x = x_inc[7:0];
          end
      endcase
    end
  end
`else
  logic [7:0] y_dec, y_inc, x_dec, x_inc;

  always_comb begin
    y_dec = cur.y - 8'(STEP);
    y_inc = cur.y + 8'(STEP);
    x_dec = cur.x - 8'(STEP);
    x_inc = cur.x + 8'(STEP);
    nxt   = cur;
    if (cur.alive) begin
      unique case (cur.dir)
        DIR_UP:    nxt.y = y_dec;
        DIR_DOWN:  nxt.y = y_inc;
        DIR_LEFT:  nxt.x = x_dec;
        DIR_RIGHT: nxt.x = x_inc;
      endcase
    end
  end
`endif

endmodule

// File: rtl/monster_move_scheduler.sv
// Owns the monster table: per-frame move sweep, kill and spawn service, drives m0..m11.
// Edge behaviour follows `MONSTER_BOUNCE_EN (clamp + reverse) or wraps when undefined.
module monster_move_scheduler
  import monster_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               kill_req,
  input  logic [3:0]         kill_idx,
  output logic               kill_ack,
  input  logic               spawn_req,
  input  logic [STATE_W-1:0] spawn_data,
  output logic               spawn_ack,
  output logic               spawn_full,
  output logic [STATE_W-1:0] m0,
  output logic [STATE_W-1:0] m1,
  output logic [STATE_W-1:0] m2,
  output logic [STATE_W-1:0] m3,
  output logic [STATE_W-1:0] m4,
  output logic [STATE_W-1:0] m5,
  output logic [STATE_W-1:0] m6,
  output logic [STATE_W-1:0] m7,
  output logic [STATE_W-1:0] m8,
  output logic [STATE_W-1:0] m9,
  output logic [STATE_W-1:0] m10,
  output logic [STATE_W-1:0] m11,
  output logic               busy,
  output logic               frame_done,
  output logic               tick_overrun
);

  sched_state_t state, state_next;
  logic [3:0]   idx, idx_next;
  logic         pending, pending_next;

  mon_state_t   mon_tbl [MONSTERS];
  mon_state_t   step_in, step_out, spawn_word;
  logic         free_found, kill_hit;
  logic [3:0]   free_idx;

  logic move_we, kill_we, spawn_we;
  logic kill_ack_next, spawn_ack_next, spawn_full_next, frame_done_next, overrun_next;

  monster_step #(.STEP(STEP)) u_step (
    .cur (step_in),
    .nxt (step_out)
  );

  always_comb begin : slot_lookup
    step_in    = mon_tbl[0];
    free_found = 1'b0;
    free_idx   = '0;
    kill_hit   = 1'b0;
    for (int unsigned i = 0; i < MONSTERS; i++) begin
      if (idx == 4'(i)) step_in = mon_tbl[i];
      if (!free_found && !mon_tbl[i][ALIVE_BIT]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
      if (kill_idx == 4'(i) && mon_tbl[i][ALIVE_BIT]) kill_hit = 1'b1;
    end
  end

  always_comb begin : spawn_clamp
    spawn_word       = mon_state_t'(spawn_data);
    spawn_word.dir   = dir_t'(spawn_data[DIR_LSB +: 2]);
    spawn_word.alive = 1'b1;
    if (spawn_data[X_LSB +: 8] > 8'(X_MAX)) spawn_word.x = 8'(X_MAX);
    if (spawn_data[Y_LSB +: 8] > 8'(Y_MAX)) spawn_word.y = 8'(Y_MAX);
  end

  always_comb begin : fsm_next
    state_next      = state;
    idx_next        = idx;
    pending_next    = pending;
    move_we         = 1'b0;
    kill_we         = 1'b0;
    spawn_we        = 1'b0;
    kill_ack_next   = 1'b0;
    spawn_ack_next  = 1'b0;
    spawn_full_next = 1'b0;
    frame_done_next = 1'b0;
    overrun_next    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_tick || pending) begin
          state_next   = ST_MOVE;
          idx_next     = '0;
          // a fresh tick arriving behind a pending one stays queued
          pending_next = frame_tick && pending;
        end else if (kill_req) begin
          kill_we       = kill_hit;
          kill_ack_next = 1'b1;
          state_next    = ST_ACK;
        end else if (spawn_req) begin
          spawn_we        = free_found;
          spawn_ack_next  = 1'b1;
          spawn_full_next = !free_found;
          state_next      = ST_ACK;
        end
      end
      ST_MOVE: begin
        move_we = 1'b1;
        if (idx == 4'(MONSTERS - 1)) begin
          state_next      = ST_IDLE;
          frame_done_next = 1'b1;
        end else begin
          idx_next = idx + 4'd1;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (state != ST_IDLE && frame_tick) begin
      if (pending) overrun_next = 1'b1;
      else         pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      pending      <= 1'b0;
      kill_ack     <= 1'b0;
      spawn_ack    <= 1'b0;
      spawn_full   <= 1'b0;
      frame_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      pending      <= pending_next;
      kill_ack     <= kill_ack_next;
      spawn_ack    <= spawn_ack_next;
      spawn_full   <= spawn_full_next;
      frame_done   <= frame_done_next;
      tick_overrun <= overrun_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MONSTERS; i++) mon_tbl[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < MONSTERS; i++) begin
        if (move_we && idx == 4'(i))
          mon_tbl[i] <= step_out;
        else if (kill_we && kill_idx == 4'(i))
          mon_tbl[i][ALIVE_BIT] <= 1'b0;
        else if (spawn_we && free_idx == 4'(i))
          mon_tbl[i] <= spawn_word;
      end
    end
  end

  assign busy = (state == ST_MOVE);

  assign m0  = mon_tbl[0];
  assign m1  = mon_tbl[1];
  assign m2  = mon_tbl[2];
  assign m3  = mon_tbl[3];
  assign m4  = mon_tbl[4];
  assign m5  = mon_tbl[5];
  assign m6  = mon_tbl[6];
  assign m7  = mon_tbl[7];
  assign m8  = mon_tbl[8];
  assign m9  = mon_tbl[9];
  assign m10 = mon_tbl[10];
  assign m11 = mon_tbl[11];

endmodule
